// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (port 0 = CPU, port 1 = loader/debug).
// Optional bus locking for atomic read-modify-write is built when DMEM_ARB_LOCK_EN is defined.

module dmem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int CNT_W      = 16,
   parameter int FIXED_PRIO = 0
) (
   input  logic             clk,
   input  logic             reset_n,

   input  logic             req0,
   input  logic             we0,
   input  logic [AW-1:0]    a0,
   input  logic [DW-1:0]    wd0,
   output logic             gnt0,
   output logic             rvalid0,
   output logic [DW-1:0]    rdata0,

   input  logic             req1,
   input  logic             we1,
   input  logic [AW-1:0]    a1,
   input  logic [DW-1:0]    wd1,
   output logic             gnt1,
   output logic             rvalid1,
   output logic [DW-1:0]    rdata1,

`ifdef DMEM_ARB_LOCK_EN
   input  logic             lock0,
   input  logic             lock1,
`endif

   output logic             mem_we,
   output logic [AW-1:0]    mem_a,
   output logic [DW-1:0]    mem_wd,
   input  logic [DW-1:0]    mem_rd,

   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic last_gnt;   // 1 = port 1 was granted most recently
   logic rr_gnt0, rr_gnt1;
   logic arb_gnt0, arb_gnt1;

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      rr_gnt0 = 1'b0;
      rr_gnt1 = 1'b0;
      if (req0 && req1) begin
         if ((FIXED_PRIO != 0) || last_gnt) rr_gnt0 = 1'b1;
         else                               rr_gnt1 = 1'b1;
      end else begin
         rr_gnt0 = req0;
         rr_gnt1 = req1;
      end
   end

`ifdef DMEM_ARB_LOCK_EN
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOCK0 = 2'd1;
   localparam logic [1:0] LOCK1 = 2'd2;

   logic [1:0] state, state_nxt;
   logic       hold0, hold1;

   // A lock persists only while its owner keeps both req and lock high; otherwise the cycle arbitrates as if idle.
   assign hold0 = (state == LOCK0) && req0 && lock0;
   assign hold1 = (state == LOCK1) && req1 && lock1;

   always_comb begin
      arb_gnt0  = rr_gnt0;
      arb_gnt1  = rr_gnt1;
      state_nxt = IDLE;
      if (hold0) begin
         arb_gnt0  = 1'b1;
         arb_gnt1  = 1'b0;
         state_nxt = LOCK0;
      end else if (hold1) begin
         arb_gnt0  = 1'b0;
         arb_gnt1  = 1'b1;
         state_nxt = LOCK1;
      end else if (rr_gnt0 && lock0) begin
         state_nxt = LOCK0;
      end else if (rr_gnt1 && lock1) begin
         state_nxt = LOCK1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end
`else
   assign arb_gnt0 = rr_gnt0;
   assign arb_gnt1 = rr_gnt1;
`endif

   // Gating with reset_n keeps the memory from being written while reset is held.
   assign gnt0 = reset_n & arb_gnt0;
   assign gnt1 = reset_n & arb_gnt1;

   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      if (gnt0) begin
         mem_we = we0;
         mem_a  = a0;
         mem_wd = wd0;
      end else if (gnt1) begin
         mem_we = we1;
         mem_a  = a1;
         mem_wd = wd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt <= 1'b1;
      end else if (gnt0) begin
         last_gnt <= 1'b0;
      end else if (gnt1) begin
         last_gnt <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvalid0 <= 1'b0;
         rdata0  <= '0;
      end else begin
         rvalid0 <= gnt0 & ~we0;
         if (gnt0 && !we0) rdata0 <= mem_rd;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvalid1 <= 1'b0;
         rdata1  <= '0;
      end else begin
         rvalid1 <= gnt1 & ~we1;
         if (gnt1 && !we1) rdata1 <= mem_rd;
      end
   end

   // Counters saturate at all ones instead of wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (gnt0 && (cnt0 != '1)) cnt0 <= cnt0 + CNT_W'(1);
         if (gnt1 && (cnt1 != '1)) cnt1 <= cnt1 + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: a round-robin instance with a memory model,
// plus a fixed-priority instance with 2-bit counters sharing the same stimulus.

module tb_dmem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        req0, we0, req1, we1;
   logic [31:0] a0, wd0, a1, wd1;
   logic        lock0, lock1;

   logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
   logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;
   logic [15:0] cnt0, cnt1;

   logic        fgnt0, fgnt1, frvalid0, frvalid1, fmem_we;
   logic [31:0] frdata0, frdata1, fmem_a, fmem_wd;
   logic [1:0]  fcnt0, fcnt1;

   logic [31:0] mem [0:255];

   int checks = 0;
   int passed = 0;
   int failed = 0;

   dmem_arbiter #(.AW(32), .DW(32), .CNT_W(16), .FIXED_PRIO(0)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .we0(we0), .a0(a0), .wd0(wd0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .a1(a1), .wd1(wd1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef DMEM_ARB_LOCK_EN
      .lock0(lock0), .lock1(lock1),
`endif
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   dmem_arbiter #(.AW(32), .DW(32), .CNT_W(2), .FIXED_PRIO(1)) u_fix (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .we0(we0), .a0(a0), .wd0(wd0),
      .gnt0(fgnt0), .rvalid0(frvalid0), .rdata0(frdata0),
      .req1(req1), .we1(we1), .a1(a1), .wd1(wd1),
      .gnt1(fgnt1), .rvalid1(frvalid1), .rdata1(frdata1),
`ifdef DMEM_ARB_LOCK_EN
      .lock0(lock0), .lock1(lock1),
`endif
      .mem_we(fmem_we), .mem_a(fmem_a), .mem_wd(fmem_wd), .mem_rd(32'h0),
      .cnt0(fcnt0), .cnt1(fcnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dmem model: synchronous write, combinational read, 256 words
   always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;
   assign mem_rd = mem[mem_a[7:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      req0 = r; we0 = w; a0 = a; wd0 = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      req1 = r; we1 = w; a1 = a; wd1 = d;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[12] = 32'hC0C0C0C0;
      reset_n = 1'b0;
      lock0 = 1'b0; lock1 = 1'b0;
      set0(1'b1, 1'b1, 32'h4, 32'hDEADBEEF);
      set1(1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      check("rst_gnt0", {31'd0, gnt0}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      tick();
      check("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_cnt0", {16'd0, cnt0}, 32'd0);

      // port 0 write then read of 0x4
      reset_n = 1'b1;
      set0(1'b1, 1'b1, 32'h4, 32'h12345678);
      #1;
      check("wr0_gnt0", {31'd0, gnt0}, 32'd1);
      check("wr0_gnt1", {31'd0, gnt1}, 32'd0);
      check("wr0_mem_we", {31'd0, mem_we}, 32'd1);
      check("wr0_mem_a", mem_a, 32'h4);
      check("wr0_mem_wd", mem_wd, 32'h12345678);
      tick();
      check("wr0_no_rvalid", {31'd0, rvalid0}, 32'd0);
      set0(1'b1, 1'b0, 32'h4, 32'h0);
      #1;
      check("rd0_gnt0", {31'd0, gnt0}, 32'd1);
      check("rd0_mem_we", {31'd0, mem_we}, 32'd0);
      tick();
      check("rd0_rvalid0", {31'd0, rvalid0}, 32'd1);
      check("rd0_rdata0", rdata0, 32'h12345678);
      check("rd0_cnt0", {16'd0, cnt0}, 32'd2);
      check("fix_cnt0_2", {30'd0, fcnt0}, 32'd2);
      set0(1'b0, 1'b0, 32'h4, 32'h0);
      #1;
      check("idle_gnt0", {31'd0, gnt0}, 32'd0);
      check("idle_mem_a", mem_a, 32'h0);
      tick();
      check("rvalid0_one_cycle", {31'd0, rvalid0}, 32'd0);
      check("rdata0_hold", rdata0, 32'h12345678);

      // port 1 write of 0x8 while port 0 idle, then port 0 reads it back
      set1(1'b1, 1'b1, 32'h8, 32'hAABBCCDD);
      #1;
      check("wr1_gnt1", {31'd0, gnt1}, 32'd1);
      check("wr1_mem_we", {31'd0, mem_we}, 32'd1);
      check("wr1_mem_a", mem_a, 32'h8);
      tick();
      set1(1'b0, 1'b0, 32'h0, 32'h0);
      set0(1'b1, 1'b0, 32'h8, 32'h0);
      #1;
      check("raw_gnt0", {31'd0, gnt0}, 32'd1);
      tick();
      check("raw_rvalid0", {31'd0, rvalid0}, 32'd1);
      check("raw_rdata0", rdata0, 32'hAABBCCDD);
      check("fix_cnt0_3", {30'd0, fcnt0}, 32'd3);

      // lone port 1 read of 0xC leaves port 1 as last granted
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      set1(1'b1, 1'b0, 32'hC, 32'h0);
      #1;
      check("rd1_gnt1", {31'd0, gnt1}, 32'd1);
      tick();
      check("rd1_rvalid1", {31'd0, rvalid1}, 32'd1);
      check("rd1_rdata1", rdata1, 32'hC0C0C0C0);
      check("rd1_rvalid0", {31'd0, rvalid0}, 32'd0);

      // continuous contention: RR alternates 0,1,0,1; fixed priority always picks port 0
      set0(1'b1, 1'b0, 32'h8, 32'h0);
      set1(1'b1, 1'b0, 32'hC, 32'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_gnt1", {31'd0, gnt1}, (i % 2 == 0) ? 32'd0 : 32'd1);
         check("rr_mem_a", mem_a, (i % 2 == 0) ? 32'h8 : 32'hC);
         check("fix_gnt0", {31'd0, fgnt0}, 32'd1);
         check("fix_gnt1", {31'd0, fgnt1}, 32'd0);
         tick();
         check("rr_rvalid0", {31'd0, rvalid0}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_rvalid1", {31'd0, rvalid1}, (i % 2 == 0) ? 32'd0 : 32'd1);
      end
      check("rr_rdata0", rdata0, 32'hAABBCCDD);
      check("rr_rdata1", rdata1, 32'hC0C0C0C0);
      check("rr_cnt0", {16'd0, cnt0}, 32'd5);
      check("rr_cnt1", {16'd0, cnt1}, 32'd4);
      check("fix_cnt0_sat", {30'd0, fcnt0}, 32'd3);
      check("fix_cnt1", {30'd0, fcnt1}, 32'd2);

      // reset asserted while port 1 read is granted
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("pre_rst_gnt1", {31'd0, gnt1}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_gnt1", {31'd0, gnt1}, 32'd0);
      check("midrst_rvalid1", {31'd0, rvalid1}, 32'd0);
      check("midrst_rdata1", rdata1, 32'd0);
      check("midrst_cnt0", {16'd0, cnt0}, 32'd0);
      check("midrst_cnt1", {16'd0, cnt1}, 32'd0);
      check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
      tick();
      check("rst_drop_rvalid1", {31'd0, rvalid1}, 32'd0);
      check("rst_drop_cnt1", {16'd0, cnt1}, 32'd0);
      reset_n = 1'b1;
      set0(1'b1, 1'b0, 32'h8, 32'h0);
      #1;
      check("post_rst_gnt0", {31'd0, gnt0}, 32'd1);
      check("post_rst_gnt1", {31'd0, gnt1}, 32'd0);
      tick();
      check("post_rst_rdata0", rdata0, 32'hAABBCCDD);
      check("post_rst_cnt0", {16'd0, cnt0}, 32'd1);
      check("post_rst_cnt1", {16'd0, cnt1}, 32'd0);
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      set1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

`ifdef DMEM_ARB_LOCK_EN
      // locked read-modify-write of 0x10 by port 0 while port 1 keeps requesting
      set0(1'b1, 1'b0, 32'h10, 32'h0);
      lock0 = 1'b1;
      #1;
      check("lk_rd_gnt0", {31'd0, gnt0}, 32'd1);
      tick();
      set0(1'b1, 1'b1, 32'h10, 32'h00000055);
      set1(1'b1, 1'b0, 32'hC, 32'h0);
      #1;
      check("lk_wr_gnt0", {31'd0, gnt0}, 32'd1);
      check("lk_wr_gnt1", {31'd0, gnt1}, 32'd0);
      check("lk_wr_mem_we", {31'd0, mem_we}, 32'd1);
      tick();
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      lock0 = 1'b0;
      #1;
      check("lk_rel_gnt1", {31'd0, gnt1}, 32'd1);
      tick();
      check("lk_rel_rvalid1", {31'd0, rvalid1}, 32'd1);
      check("lk_mem10", mem[16], 32'h00000055);
      set1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
